// File: rtl/lc4_seq_alu_if.sv
// Request/response bundle between register-read and writeback for lc4_seq_alu.
// The slave side is the ALU; the master side is the issuing pipeline stage.
interface lc4_seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [15:0]      i_insn;
  logic [WIDTH-1:0] i_r1data;
  logic [WIDTH-1:0] i_r2data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_illegal;
  logic             i_abort;

  modport master (
    output i_valid, i_insn, i_r1data, i_r2data, i_ready, i_abort,
    input  o_ready, o_valid, o_result, o_illegal
  );

  modport slave (
    input  i_valid, i_insn, i_r1data, i_r2data, i_ready, i_abort,
    output o_ready, o_valid, o_result, o_illegal
  );
endinterface

// File: rtl/lc4_seq_alu.sv
// Multi-cycle LC4 ALU: simple ops finish on the accept edge, MUL (shift-add when
// FAST_MUL=0), DIV and MOD iterate one bit per cycle; the result is held until taken.
module lc4_seq_alu #(
  parameter int WIDTH    = 16,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  lc4_seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_MOD} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [3:0]              opc;
  logic [2:0]              sub3;
  logic [1:0]              sub2;
  logic [1:0]              csub;
  logic [3:0]              shamt;
  logic [WIDTH-1:0]        r1, r2;
  logic signed [WIDTH-1:0] r1_s, r2_s, imm7_s;
  logic [WIDTH-1:0]        imm5_s, imm7_u, imm9_s, hiconst;
  logic                    unused_insn;

  assign opc     = bus.i_insn[15:12];
  assign sub3    = bus.i_insn[5:3];
  assign sub2    = bus.i_insn[5:4];
  assign csub    = bus.i_insn[8:7];
  assign shamt   = bus.i_insn[3:0];
  assign r1      = bus.i_r1data;
  assign r2      = bus.i_r2data;
  assign r1_s    = bus.i_r1data;
  assign r2_s    = bus.i_r2data;
  assign imm5_s  = {{(WIDTH-5){bus.i_insn[4]}}, bus.i_insn[4:0]};
  assign imm7_s  = {{(WIDTH-7){bus.i_insn[6]}}, bus.i_insn[6:0]};
  assign imm7_u  = WIDTH'(bus.i_insn[6:0]);
  assign imm9_s  = {{(WIDTH-9){bus.i_insn[8]}}, bus.i_insn[8:0]};
  assign hiconst = WIDTH'({bus.i_insn[7:0], r1[7:0]});
  // Register-number fields are resolved upstream; only the operand values matter here.
  assign unused_insn = ^bus.i_insn[11:9];

  // Three-way compare code: 1 when greater, 0 when equal, all-ones when less.
  function automatic logic [WIDTH-1:0] cmp_code(input logic lt, input logic gt);
    if (lt) return '1;
    if (gt) return {{(WIDTH-1){1'b0}}, 1'b1};
    return '0;
  endfunction

  logic [WIDTH-1:0] simple_res;
  logic             simple_ill;
  logic             start_iter;
  kind_t            iter_kind;

  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    start_iter = 1'b0;
    iter_kind  = K_MUL;
    case (opc)
      4'b0001: begin
        case (sub3)
          3'b000: simple_res = r1 + r2;
          3'b001: begin
            if (FAST_MUL) simple_res = r1 * r2;
            else begin
              start_iter = 1'b1;
              iter_kind  = K_MUL;
            end
          end
          3'b010: simple_res = r1 - r2;
          3'b011: begin
            start_iter = (r2 != '0);
            iter_kind  = K_DIV;
          end
          default: simple_res = r1 + imm5_s;
        endcase
      end
      4'b0010: begin
        case (csub)
          2'b00:   simple_res = cmp_code(r1_s < r2_s, r1_s > r2_s);
          2'b01:   simple_res = cmp_code(r1 < r2, r1 > r2);
          2'b10:   simple_res = cmp_code(r1_s < imm7_s, r1_s > imm7_s);
          default: simple_res = cmp_code(r1 < imm7_u, r1 > imm7_u);
        endcase
      end
      4'b0101: begin
        case (sub3)
          3'b000:  simple_res = r1 & r2;
          3'b001:  simple_res = ~r1;
          3'b010:  simple_res = r1 | r2;
          3'b011:  simple_res = r1 ^ r2;
          default: simple_res = r1 & imm5_s;
        endcase
      end
      4'b1010: begin
        case (sub2)
          2'b00:   simple_res = r1 << shamt;
          2'b01:   simple_res = r1_s >>> shamt;
          2'b10:   simple_res = r1 >> shamt;
          default: begin
            start_iter = (r2 != '0);
            iter_kind  = K_MOD;
          end
        endcase
      end
      4'b1001: simple_res = imm9_s;
      4'b1101: simple_res = hiconst;
      default: simple_ill = 1'b1;
    endcase
  end

  // One iteration: shift-add (acc += multiplicand when multiplier LSB set) or
  // restoring division with acc as partial remainder and opa shifting quotient bits in.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] step_acc, step_opa, step_opb;

  always_comb begin
    shifted  = {acc_q, opa_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, opb_q});
    diff     = shifted[WIDTH-1:0] - opb_q;
    step_acc = acc_q;
    step_opa = opa_q;
    step_opb = opb_q;
    if (kind_q == K_MUL) begin
      step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end else begin
      step_acc = ge ? diff : shifted[WIDTH-1:0];
      step_opa = {opa_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (bus.i_abort) begin
      state_d   = S_IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            if (start_iter) begin
              state_d   = S_BUSY;
              kind_d    = iter_kind;
              cnt_d     = CW'(WIDTH-1);
              acc_d     = '0;
              opa_d     = r1;
              opb_d     = r2;
              illegal_d = 1'b0;
            end else begin
              state_d   = S_DONE;
              result_d  = simple_res;
              illegal_d = simple_ill;
            end
          end
        end
        S_BUSY: begin
          acc_d = step_acc;
          opa_d = step_opa;
          opb_d = step_opb;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = (kind_q == K_DIV) ? step_opa : step_acc;
          end
        end
        S_DONE: begin
          if (bus.i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kind_q    <= K_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.o_ready   = (state_q == S_IDLE);
  assign bus.o_valid   = (state_q == S_DONE);
  assign bus.o_result  = result_q;
  assign bus.o_illegal = illegal_q;
endmodule

// File: tb/tb_lc4_seq_alu.sv
// Directed bench for lc4_seq_alu: a WIDTH=16 shift-add instance and a WIDTH=32 FAST_MUL
// instance, checked against an arithmetic reference model plus literal expectations.
module tb_lc4_seq_alu;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lc4_seq_alu_if #(.WIDTH(16)) b16 ();
  lc4_seq_alu_if #(.WIDTH(32)) b32 ();

  lc4_seq_alu #(.WIDTH(16), .FAST_MUL(1'b0)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  lc4_seq_alu #(.WIDTH(32), .FAST_MUL(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  always #5 clk = ~clk;

  function automatic logic get_valid(input int w);
    return (w == 32) ? b32.o_valid : b16.o_valid;
  endfunction
  function automatic logic get_ready(input int w);
    return (w == 32) ? b32.o_ready : b16.o_ready;
  endfunction
  function automatic logic get_ill(input int w);
    return (w == 32) ? b32.o_illegal : b16.o_illegal;
  endfunction
  function automatic logic [31:0] get_res(input int w);
    return (w == 32) ? b32.o_result : {16'h0, b16.o_result};
  endfunction

  task automatic drive(input int w, input logic v, input logic [15:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      b32.i_valid = v; b32.i_insn = insn; b32.i_r1data = a; b32.i_r2data = b;
    end else begin
      b16.i_valid = v; b16.i_insn = insn; b16.i_r1data = a[15:0]; b16.i_r2data = b[15:0];
    end
  endtask
  task automatic set_ready(input int w, input logic v);
    if (w == 32) b32.i_ready = v; else b16.i_ready = v;
  endtask
  task automatic set_abort(input int w, input logic v);
    if (w == 32) b32.i_abort = v; else b16.i_abort = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input int w, input logic [31:0] v);
    logic signed [15:0] h;
    logic signed [31:0] f;
    h = v[15:0];
    f = v;
    return (w == 32) ? longint'(f) : longint'(h);
  endfunction

  function automatic longint cmpv(input longint x, input longint y, input longint m);
    if (x < y) return m;
    if (x > y) return 1;
    return 0;
  endfunction

  // Returns {illegal, result}
  function automatic logic [32:0] model(input int w, input logic [15:0] insn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub, sa, sb, i5, i7, i9, r;
    logic signed [4:0] s5;
    logic signed [6:0] s7;
    logic signed [8:0] s9;
    logic ill;
    int sh;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = sx(w, a);
    sb = sx(w, b);
    s5 = insn[4:0]; i5 = s5;
    s7 = insn[6:0]; i7 = s7;
    s9 = insn[8:0]; i9 = s9;
    sh = int'(insn[3:0]);
    r = 0;
    ill = 1'b0;
    case (insn[15:12])
      4'h1: case (insn[5:3])
        3'd0: r = ua + ub;
        3'd1: r = ua * ub;
        3'd2: r = ua - ub;
        3'd3: r = (ub == 0) ? 0 : ua / ub;
        default: r = ua + i5;
      endcase
      4'h2: case (insn[8:7])
        2'd0: r = cmpv(sa, sb, mask);
        2'd1: r = cmpv(ua, ub, mask);
        2'd2: r = cmpv(sa, i7, mask);
        default: r = cmpv(ua, longint'(insn[6:0]), mask);
      endcase
      4'h5: case (insn[5:3])
        3'd0: r = ua & ub;
        3'd1: r = ~ua;
        3'd2: r = ua | ub;
        3'd3: r = ua ^ ub;
        default: r = ua & i5;
      endcase
      4'hA: case (insn[5:4])
        2'd0: r = ua << sh;
        2'd1: r = sa >>> sh;
        2'd2: r = ua >> sh;
        default: r = (ub == 0) ? 0 : ua % ub;
      endcase
      4'h9: r = i9;
      4'hD: r = (ua & 255) | (longint'(insn[7:0]) << 8);
      default: ill = 1'b1;
    endcase
    return {ill, 32'(r & mask)};
  endfunction

  // The 16-bit instance multiplies by shift-add, the 32-bit one combinationally.
  function automatic bit is_iter(input int w, input logic [15:0] insn, input logic [31:0] b);
    logic [31:0] bm;
    bm = (w == 32) ? b : {16'h0, b[15:0]};
    if (insn[15:12] == 4'h1 && insn[5:3] == 3'd1) return (w != 32);
    if (insn[15:12] == 4'h1 && insn[5:3] == 3'd3) return (bm != 0);
    if (insn[15:12] == 4'hA && insn[5:4] == 2'd3) return (bm != 0);
    return 1'b0;
  endfunction

  // ---------------- compare process ----------------
  int          exp_w   = 16;
  logic [31:0] exp_res = '0;
  logic        exp_ill = 1'b0;
  bit          exp_on  = 1'b0;

  always @(negedge clk) begin
    if (exp_on && get_valid(exp_w)) begin
      checks++;
      if (get_res(exp_w) !== exp_res || get_ill(exp_w) !== exp_ill) begin
        errors++;
        $display("FAIL model_cmp w%0d t=%0t: result=%h illegal=%b, required result=%h illegal=%b",
                 exp_w, $time, get_res(exp_w), get_ill(exp_w), exp_res, exp_ill);
      end
    end
  end

  // Issue one op, measure edges from the accept edge (counted as 1) to o_valid,
  // stall the consumer, then complete the handshake.
  task automatic do_op(input int w, input logic [15:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input int stall, input logic [31:0] lit,
                       input string nm);
    logic [32:0] m;
    int lat, exp_lat;
    bit seen, rdy_bad;
    m = model(w, insn, a, b);
    exp_lat = is_iter(w, insn, b) ? w + 1 : 1;
    @(negedge clk);
    chk({nm, "_ready_before"}, 32'(get_ready(w)), 32'd1);
    exp_w = w; exp_res = m[31:0]; exp_ill = m[32]; exp_on = 1'b1;
    drive(w, 1'b1, insn, a, b);
    @(posedge clk);
    #1 drive(w, 1'b0, 16'hFFFF, $urandom, $urandom);
    lat = 1; seen = 1'b0; rdy_bad = 1'b0;
    while (!seen && lat <= 100) begin
      @(negedge clk);
      if (get_valid(w)) seen = 1'b1;
      else begin
        if (get_ready(w)) rdy_bad = 1'b1;
        @(posedge clk);
        lat++;
      end
    end
    chk({nm, "_latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({nm, "_ready_low_busy"}, 32'(rdy_bad), 32'd0);
    chk({nm, "_result"}, get_res(w), lit);
    repeat (stall) @(negedge clk);
    set_ready(w, 1'b1);
    @(posedge clk);
    #1 set_ready(w, 1'b0);
    exp_on = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_after"}, 32'(get_ready(w)), 32'd1);
    chk({nm, "_valid_after"}, 32'(get_valid(w)), 32'd0);
  endtask

  task automatic watch_quiet(input int w, input int n, input string nm);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (get_valid(w)) bad = 1'b1;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(16, 1'b0, 16'h0, 32'h0, 32'h0);
    drive(32, 1'b0, 16'h0, 32'h0, 32'h0);
    set_ready(16, 1'b0); set_ready(32, 1'b0);
    set_abort(16, 1'b0); set_abort(32, 1'b0);
    #12;
    for (int w = 16; w <= 32; w += 16) begin
      chk($sformatf("rst_ready_w%0d", w), 32'(get_ready(w)), 32'd1);
      chk($sformatf("rst_valid_w%0d", w), 32'(get_valid(w)), 32'd0);
      chk($sformatf("rst_result_w%0d", w), get_res(w), 32'd0);
      chk($sformatf("rst_illegal_w%0d", w), 32'(get_ill(w)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16, 16'h1042, 32'h7FFF, 32'h0001, 5, 32'h8000, "add");
    do_op(16, 16'h1008, 32'h00FF, 32'h0100, 1, 32'hFF00, "mul_a");
    do_op(16, 16'h1008, 32'h0003, 32'h0005, 0, 32'h000F, "mul_b");
    do_op(16, 16'h1008, 32'hFFFF, 32'hFFFF, 0, 32'h0001, "mul_wrap");
    do_op(16, 16'h1018, 32'd100,  32'd7,    0, 32'd14,   "div");
    do_op(16, 16'hA030, 32'd100,  32'd7,    0, 32'd2,    "mod");
    do_op(16, 16'h1018, 32'd100,  32'd0,    0, 32'd0,    "div_zero");
    do_op(16, 16'hA030, 32'd100,  32'd0,    0, 32'd0,    "mod_zero");
    do_op(16, 16'h1018, 32'hFFFF, 32'd3,    0, 32'h5555, "div_big");
    do_op(16, 16'hA030, 32'hFFFF, 32'h10,   0, 32'h000F, "mod_big");
    do_op(16, 16'h1018, 32'd5,    32'd9,    0, 32'd0,    "div_small");
    do_op(16, 16'h2000, 32'hFFFF, 32'h0001, 0, 32'hFFFF, "cmp");
    do_op(16, 16'h2080, 32'hFFFF, 32'h0001, 0, 32'h0001, "cmpu");
    do_op(16, 16'h217F, 32'hFFFF, 32'h0000, 0, 32'h0000, "cmpi");
    do_op(16, 16'h21FF, 32'h0010, 32'h0000, 0, 32'hFFFF, "cmpiu");
    do_op(16, 16'h1010, 32'd5,    32'd7,    0, 32'hFFFE, "sub");
    do_op(16, 16'h5018, 32'hF0F0, 32'hFF00, 0, 32'h0FF0, "xor");
    do_op(16, 16'h5008, 32'h00F0, 32'h0000, 0, 32'hFF0F, "not");
    do_op(16, 16'h5030, 32'h1234, 32'h0000, 0, 32'h1230, "andi");
    do_op(16, 16'hA004, 32'h1234, 32'h0000, 0, 32'h2340, "sll");
    do_op(16, 16'hA013, 32'h8000, 32'h0000, 0, 32'hF000, "sra");
    do_op(16, 16'hA024, 32'h8000, 32'h0000, 0, 32'h0800, "srl");
    do_op(16, 16'h91FF, 32'h0000, 32'h0000, 0, 32'hFFFF, "const");

    do_op(32, 16'h1030, 32'h0000_0005, 32'h0,   0, 32'hFFFF_FFF5, "addi32");
    do_op(32, 16'hD05A, 32'hABCD_1234, 32'h0,   0, 32'h0000_5A34, "hiconst32");
    do_op(32, 16'h3000, 32'h1234_5678, 32'h9,   2, 32'h0,         "illegal32");
    do_op(32, 16'h1008, 32'h0001_0003, 32'h0002_0005, 0, 32'h000B_000F, "mul32_fast");
    do_op(32, 16'h1018, 32'hFFFF_FFFF, 32'h10,  0, 32'h0FFF_FFFF, "div32");
    do_op(32, 16'hA030, 32'h1234_5678, 32'h100, 0, 32'h0000_0078, "mod32");
    do_op(32, 16'hA014, 32'h8000_0000, 32'h0,   0, 32'hF800_0000, "sra32");
    do_op(32, 16'h2000, 32'h8000_0000, 32'h1,   0, 32'hFFFF_FFFF, "cmp32");
    do_op(32, 16'h9100, 32'h0,         32'h0,   0, 32'hFFFF_FF00, "const32");
    do_op(32, 16'h1010, 32'h0,         32'h1,   0, 32'hFFFF_FFFF, "sub32");

    // Abort during the fifth BUSY cycle of a DIV; the held result must survive.
    do_op(16, 16'h1042, 32'd1, 32'd2, 0, 32'd3, "add_pre_abort");
    @(negedge clk);
    drive(16, 1'b1, 16'h1018, 32'd100, 32'd7);
    @(posedge clk);
    #1 drive(16, 1'b0, 16'h0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_abort(16, 1'b1);
    @(posedge clk);
    #1 set_abort(16, 1'b0);
    @(negedge clk);
    chk("abort_busy_ready", 32'(get_ready(16)), 32'd1);
    chk("abort_busy_valid", 32'(get_valid(16)), 32'd0);
    chk("abort_busy_result_kept", get_res(16), 32'd3);
    watch_quiet(16, 20, "abort_busy_no_valid");

    // A request coinciding with abort is dropped.
    @(negedge clk);
    drive(16, 1'b1, 16'h1042, 32'd1, 32'd1);
    set_abort(16, 1'b1);
    @(posedge clk);
    #1 drive(16, 1'b0, 16'h0, 32'h0, 32'h0);
    set_abort(16, 1'b0);
    @(negedge clk);
    chk("abort_req_ready", 32'(get_ready(16)), 32'd1);
    chk("abort_req_valid", 32'(get_valid(16)), 32'd0);
    chk("abort_req_result_kept", get_res(16), 32'd3);

    // Abort while an illegal result is held clears o_illegal.
    @(negedge clk);
    drive(32, 1'b1, 16'h3000, 32'h1, 32'h1);
    @(posedge clk);
    #1 drive(32, 1'b0, 16'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("illegal_held_valid", 32'(get_valid(32)), 32'd1);
    chk("illegal_held_flag", 32'(get_ill(32)), 32'd1);
    set_abort(32, 1'b1);
    @(posedge clk);
    #1 set_abort(32, 1'b0);
    @(negedge clk);
    chk("abort_done_valid", 32'(get_valid(32)), 32'd0);
    chk("abort_done_illegal", 32'(get_ill(32)), 32'd0);
    chk("abort_done_ready", 32'(get_ready(32)), 32'd1);

    // Asynchronous reset in the middle of a shift-add MUL.
    @(negedge clk);
    drive(16, 1'b1, 16'h1008, 32'd3, 32'd5);
    @(posedge clk);
    #1 drive(16, 1'b0, 16'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(get_ready(16)), 32'd1);
    chk("async_rst_valid", 32'(get_valid(16)), 32'd0);
    chk("async_rst_result", get_res(16), 32'd0);
    chk("async_rst_illegal", 32'(get_ill(16)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(16, 20, "post_rst_no_valid");
    do_op(16, 16'h1042, 32'h1111, 32'h2222, 0, 32'h3333, "add_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
